// File: rtl/resampler_pkg.sv
// resampler_pkg: shared definitions for the multichannel resampler slice.
//   - state_t : sweep FSM states (IDLE, ADV, FETCH, INTERP, EMIT)
//   - DEF_*   : default sample width, phase fraction and step integer widths
//   - step_t  : phase increment type for the default configuration
package resampler_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_FRAC_W = 12;
  localparam int DEF_INT_W  = 4;
  localparam int DEF_STEP_W = DEF_INT_W + DEF_FRAC_W;

  typedef enum logic [2:0] {
    IDLE,
    ADV,
    FETCH,
    INTERP,
    EMIT
  } state_t;

  typedef logic [DEF_STEP_W-1:0] step_t;

endpackage

// File: rtl/multichannel_resampler_if.sv
// multichannel_resampler_if: source-fetch handshake plus tagged output bus.
//   req_valid/req_ch      : resampler asks the fetcher for the next sample of req_ch
//   resp_data/resp_valid  : fetcher answers; a beat counts only while req_valid=1
//   sample_out/_ch/_valid : interpolated sample towards the mixer
// Modports: master = resampler side, slave = fetcher/mixer side.
import resampler_pkg::*;

interface multichannel_resampler_if #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CH_W  = 2
);

  logic                    req_valid;
  logic [CH_W-1:0]         req_ch;
  logic signed [WIDTH-1:0] resp_data;
  logic                    resp_valid;
  logic signed [WIDTH-1:0] sample_out;
  logic [CH_W-1:0]         sample_out_ch;
  logic                    sample_out_valid;

  modport master (
    output req_valid, req_ch, sample_out, sample_out_ch, sample_out_valid,
    input  resp_data, resp_valid
  );

  modport slave (
    input  req_valid, req_ch, sample_out, sample_out_ch, sample_out_valid,
    output resp_data, resp_valid
  );

endinterface

// File: rtl/resampler_lerp.sv
// resampler_lerp: registered linear interpolator, one cycle latency.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : load a new result this cycle
//   hold       : 1 = zero-order hold (result = cur), 0 = linear interpolation
//   prev, cur  : the two most recent source samples (signed)
//   frac       : unsigned fractional phase between prev and cur
//   result     : prev + floor((cur-prev)*frac / 2^FRAC_W), held between loads
import resampler_pkg::*;

module resampler_lerp #(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    hold,
  input  logic signed [WIDTH-1:0] prev,
  input  logic signed [WIDTH-1:0] cur,
  input  logic [FRAC_W-1:0]       frac,
  output logic signed [WIDTH-1:0] result
);

  // The difference needs one extra bit so that e.g. 32767 - (-32768) does
  // not wrap; frac is zero-extended so the signed multiply treats it as
  // a non-negative weight.
  logic signed [WIDTH:0]          diff;
  logic signed [WIDTH+FRAC_W+1:0] prod;

  assign diff = {cur[WIDTH-1], cur} - {prev[WIDTH-1], prev};
  assign prod = diff * $signed({1'b0, frac});

  // Multiply, floor shift and add are registered together. The arithmetic
  // shift rounds towards minus infinity, and the interpolated value always
  // lies between prev and cur, so truncating back to WIDTH bits is exact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
    end else if (en) begin
      if (hold) begin
        result <= cur;
      end else begin
        result <= WIDTH'(prev + (prod >>> FRAC_W));
      end
    end
  end

endmodule

// File: rtl/multichannel_resampler.sv
// multichannel_resampler: time-multiplexed pull-based sample-rate converter.
// Each out_strobe sweeps channels 0..CHANNELS-1: advance the phase by step,
// fetch as many source samples as the integer carry demands, interpolate and
// emit one tagged sample per channel.
//   clk, rst_n  : clock, asynchronous active-low reset
//   step        : unsigned Q(INT_W).(FRAC_W) phase increment, taken in ADV
//   out_strobe  : output-rate tick; ignored (and flagged) while busy
//   interp_mode : only with RESAMPLER_INTERP_SEL_EN; 1 = zero-order hold
//   overrun     : sticky flag, a strobe arrived while a sweep was running
//   bus         : multichannel_resampler_if master (fetch + output)
// Optional feature macro: RESAMPLER_INTERP_SEL_EN.
import resampler_pkg::*;

module multichannel_resampler #(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = 4,
  parameter int FRAC_W   = DEF_FRAC_W,
  parameter int INT_W    = DEF_INT_W,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int STEP_W  = INT_W + FRAC_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [STEP_W-1:0]   step,
  input  logic                out_strobe,
`ifdef RESAMPLER_INTERP_SEL_EN
  input  logic                interp_mode,
`endif
  output logic                overrun,
  multichannel_resampler_if.master bus
);

  state_t                  state_q, state_d;
  logic [CH_W-1:0]         ch_q;
  logic [INT_W:0]          fetch_cnt_q;
  logic signed [WIDTH-1:0] prev_q [CHANNELS];
  logic signed [WIDTH-1:0] cur_q  [CHANNELS];
  logic [FRAC_W-1:0]       frac_q [CHANNELS];
  logic [STEP_W:0]         adv_sum;
  logic                    last_ch;
  logic                    hold_q;
  logic                    out_valid_q;
  logic [CH_W-1:0]         out_ch_q;
  logic signed [WIDTH-1:0] lerp_result;

  // The carry out of the fraction (bits STEP_W..FRAC_W) is the number of
  // new source samples this channel must pull before interpolating.
  assign adv_sum = {1'b0, step} + {{(INT_W+1){1'b0}}, frac_q[ch_q]};
  assign last_ch = (ch_q == CH_W'(CHANNELS-1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Sweep sequencing: one ADV/[FETCH]/INTERP/EMIT pass per channel, back to
  // IDLE after the last channel has been emitted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (out_strobe) state_d = ADV;
      ADV:     state_d = (adv_sum[STEP_W:FRAC_W] != '0) ? FETCH : INTERP;
      FETCH:   if (bus.resp_valid && fetch_cnt_q == {{INT_W{1'b0}}, 1'b1})
                 state_d = INTERP;
      INTERP:  state_d = EMIT;
      EMIT:    state_d = last_ch ? IDLE : ADV;
      default: state_d = IDLE;
    endcase
  end

  // Per-channel history and phase, channel pointer, fetch counter and the
  // sticky overrun flag. A fetch beat shifts the two-sample history window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q        <= '0;
      fetch_cnt_q <= '0;
      overrun     <= 1'b0;
      hold_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        prev_q[i] <= '0;
        cur_q[i]  <= '0;
        frac_q[i] <= '0;
      end
    end else begin
      out_valid_q <= (state_q == INTERP);
      if (out_strobe && state_q != IDLE) begin
        overrun <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (out_strobe) ch_q <= '0;
        end
        ADV: begin
          frac_q[ch_q] <= adv_sum[FRAC_W-1:0];
          fetch_cnt_q  <= adv_sum[STEP_W:FRAC_W];
`ifdef RESAMPLER_INTERP_SEL_EN
          hold_q       <= interp_mode;
`else
          hold_q       <= 1'b0;
`endif
        end
        FETCH: begin
          if (bus.resp_valid) begin
            prev_q[ch_q] <= cur_q[ch_q];
            cur_q[ch_q]  <= bus.resp_data;
            fetch_cnt_q  <= fetch_cnt_q - 1'b1;
          end
        end
        INTERP: begin
          out_ch_q <= ch_q;
        end
        EMIT: begin
          if (!last_ch) ch_q <= ch_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  resampler_lerp #(
    .WIDTH  (WIDTH),
    .FRAC_W (FRAC_W)
  ) u_lerp (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (state_q == INTERP),
    .hold   (hold_q),
    .prev   (prev_q[ch_q]),
    .cur    (cur_q[ch_q]),
    .frac   (frac_q[ch_q]),
    .result (lerp_result)
  );

  assign bus.req_valid        = (state_q == FETCH);
  assign bus.req_ch           = ch_q;
  assign bus.sample_out       = lerp_result;
  assign bus.sample_out_ch    = out_ch_q;
  assign bus.sample_out_valid = out_valid_q;

endmodule

// File: tb/tb_multichannel_resampler.sv
// tb_multichannel_resampler: self-checking bench for multichannel_resampler.
// A fetcher model serves per-channel source arrays with random stalls and
// stray resp_valid pulses; a reference model tracks each channel as
// "samples consumed so far + fractional phase" and computes the expected
// sample with plain integer floor division. Define RESAMPLER_INTERP_SEL_EN
// to exercise zero-order hold as well.
import resampler_pkg::*;

module tb_multichannel_resampler;

  localparam int WIDTH    = 16;
  localparam int CHANNELS = 4;
  localparam int FRAC_W   = 12;
  localparam int INT_W    = 4;
  localparam int CH_W     = 2;
  localparam int SRC_LEN  = 1024;
  localparam int ONE      = 1 << FRAC_W;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  step_t step = '0;
  logic  out_strobe = 1'b0;
  logic  overrun;
`ifdef RESAMPLER_INTERP_SEL_EN
  logic  interp_mode = 1'b0;
`endif

  multichannel_resampler_if #(.WIDTH(WIDTH), .CH_W(CH_W)) bus ();

  multichannel_resampler #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS),
    .FRAC_W   (FRAC_W),
    .INT_W    (INT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .step        (step),
    .out_strobe  (out_strobe),
`ifdef RESAMPLER_INTERP_SEL_EN
    .interp_mode (interp_mode),
`endif
    .overrun     (overrun),
    .bus         (bus.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic signed [WIDTH-1:0] src [CHANNELS][SRC_LEN];
  int  idx [CHANNELS];
  bit  stall_all = 1'b0;
  int  valid_pct = 70;
  bit  will_consume = 1'b0;
  int  consume_ch = 0;

  int  m_frac [CHANNELS];
  int  m_n    [CHANNELS];
  int  m_last [CHANNELS];
  int  dut_last [CHANNELS];
  int  exp_next = 0;
  int  out_count = 0;
  int  mc, macc, mpv, mcv, mev;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  function automatic int src_at(input int c, input int n);
    if (n < 0 || n >= SRC_LEN) return 0;
    return int'(src[c][n]);
  endfunction

  function automatic int lerp_ref(input int pv, input int cv, input int f);
    longint d, q;
    d = longint'(cv - pv) * longint'(f);
    q = d / ONE;
    if (d < 0 && (d % ONE) != 0) q = q - 1;
    return pv + int'(q);
  endfunction

  // Fetcher model: a beat is consumed when req_valid and resp_valid were
  // both high across a rising edge; stray resp_valid pulses are allowed.
  always @(negedge clk) begin
    will_consume = rst_n && bus.req_valid && bus.resp_valid;
    consume_ch   = int'(bus.req_ch);
  end

  initial begin
    bus.resp_valid = 1'b0;
    bus.resp_data  = '0;
    for (int c = 0; c < CHANNELS; c++) idx[c] = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        for (int c = 0; c < CHANNELS; c++) idx[c] = 0;
      end else if (will_consume) begin
        idx[consume_ch] = idx[consume_ch] + 1;
      end
      bus.resp_valid = !stall_all && ($urandom_range(99) < valid_pct);
      bus.resp_data  = WIDTH'(src_at(int'(bus.req_ch), idx[int'(bus.req_ch)]));
    end
  end

  // Reference model and output compare: every valid output is checked
  // against the expected channel order and the expected sample value.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        m_frac[c] = 0;
        m_n[c]    = 0;
      end
      exp_next = 0;
    end else if (bus.sample_out_valid) begin
      mc   = exp_next;
      macc = m_frac[mc] + int'(step);
      m_n[mc]    = m_n[mc] + macc / ONE;
      m_frac[mc] = macc % ONE;
      mpv = (m_n[mc] >= 2) ? src_at(mc, m_n[mc] - 2) : 0;
      mcv = (m_n[mc] >= 1) ? src_at(mc, m_n[mc] - 1) : 0;
      mev = lerp_ref(mpv, mcv, m_frac[mc]);
`ifdef RESAMPLER_INTERP_SEL_EN
      if (interp_mode) mev = mcv;
`endif
      checkOutput("sample_out_ch", longint'(bus.sample_out_ch), longint'(mc));
      checkOutput("sample_out", longint'(bus.sample_out), longint'(mev));
      m_last[mc] = mev;
      dut_last[mc] = int'(bus.sample_out);
      exp_next = (exp_next + 1) % CHANNELS;
      out_count = out_count + 1;
    end
  end

  task automatic doReset();
    rst_n = 1'b0;
    out_strobe = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One full sweep: strobe, optional second strobe while busy, wait for all
  // channels to be emitted, then check fetch counts against the model.
  task automatic applyStimulus(input step_t s, input bit extra_strobe, input bit check_lat);
    int start, cyc, lat;
    bit seen;
    start = out_count;
    step = s;
    out_strobe = 1'b1;
    @(posedge clk);
    #1 out_strobe = 1'b0;
    cyc = 0;
    lat = 0;
    seen = 1'b0;
    while (out_count < start + CHANNELS && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (extra_strobe && cyc == 1) out_strobe = 1'b1;
      if (extra_strobe && cyc == 2) out_strobe = 1'b0;
      if (!seen && bus.sample_out_valid) begin
        seen = 1'b1;
        lat = cyc;
      end
    end
    if (out_count < start + CHANNELS)
      checkOutput("sweep_timeout", out_count - start, CHANNELS);
    if (check_lat) checkOutput("latency", lat, 3);
    repeat (2) @(posedge clk);
    #2;
    for (int c = 0; c < CHANNELS; c++) checkOutput("fetch_count", idx[c], m_n[c]);
  endtask

  task automatic fillRandom();
    for (int c = 0; c < CHANNELS; c++)
      for (int n = 0; n < SRC_LEN; n++)
        src[c][n] = WIDTH'($urandom());
  endtask

  int lit1 [3] = '{0, 100, 200};
  int lit2 [5] = '{0, 0, 50, 100, 150};
  int fet2 [5] = '{0, 1, 1, 2, 2};
  int lit3 [2] = '{100, 300};
  int lit4 [4] = '{0, 100, 100, 200};
  step_t rs;
  bit got;

  initial begin
    fillRandom();
    doReset();
    checkOutput("reset_sample_out", longint'(bus.sample_out), 0);
    checkOutput("reset_out_valid", longint'(bus.sample_out_valid), 0);
    checkOutput("reset_out_ch", longint'(bus.sample_out_ch), 0);
    checkOutput("reset_req_valid", longint'(bus.req_valid), 0);
    checkOutput("reset_req_ch", longint'(bus.req_ch), 0);
    checkOutput("reset_overrun", longint'(overrun), 0);

    $display("[TB] unity step");
    fillRandom();
    src[0][0] = 16'sd100; src[0][1] = 16'sd200; src[0][2] = 16'sd300;
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(16'h1000, 1'b0, 1'b0);
      checkOutput("unity_dut", dut_last[0], lit1[i]);
      checkOutput("unity_model", m_last[0], lit1[i]);
    end
    checkOutput("no_overrun", longint'(overrun), 0);

    $display("[TB] half step");
    src[0][0] = 16'sd100; src[0][1] = 16'sd200;
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(16'h0800, 1'b0, (i % 2) == 0);
      checkOutput("half_dut", dut_last[0], lit2[i]);
      checkOutput("half_model", m_last[0], lit2[i]);
      checkOutput("half_fetches", idx[0], fet2[i]);
    end

    $display("[TB] double step");
    src[0][0] = 16'sd100; src[0][1] = 16'sd200; src[0][2] = 16'sd300; src[0][3] = 16'sd400;
    doReset();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(16'h2000, 1'b0, 1'b0);
      checkOutput("double_dut", dut_last[0], lit3[i]);
      checkOutput("double_model", m_last[0], lit3[i]);
    end

    $display("[TB] floor rounding");
    src[0][0] = -16'sd1;
    doReset();
    applyStimulus(16'h1800, 1'b0, 1'b0);
    checkOutput("floor_neg_half", dut_last[0], -1);
    checkOutput("floor_neg_half_model", m_last[0], -1);
    src[0][0] = -16'sd4; src[0][1] = 16'sd4;
    doReset();
    applyStimulus(16'h2400, 1'b0, 1'b0);
    checkOutput("floor_quarter", dut_last[0], -2);
    checkOutput("floor_quarter_model", m_last[0], -2);

    $display("[TB] overrun");
    fillRandom();
    doReset();
    applyStimulus(16'h1000, 1'b1, 1'b0);
    checkOutput("overrun_set", longint'(overrun), 1);
    applyStimulus(16'h0C00, 1'b0, 1'b0);
    checkOutput("overrun_sticky", longint'(overrun), 1);

    $display("[TB] reset during fetch");
    stall_all = 1'b1;
    step = 16'h1000;
    out_strobe = 1'b1;
    @(posedge clk);
    #1 out_strobe = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = bus.req_valid;
    end
    checkOutput("req_valid_seen", longint'(got), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset_req_valid", longint'(bus.req_valid), 0);
    checkOutput("midreset_overrun", longint'(overrun), 0);
    checkOutput("midreset_sample_out", longint'(bus.sample_out), 0);
    checkOutput("midreset_out_valid", longint'(bus.sample_out_valid), 0);
    stall_all = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(16'h0000, 1'b0, 1'b1);
    for (int c = 0; c < CHANNELS; c++) checkOutput("post_reset_zero", dut_last[c], 0);

`ifdef RESAMPLER_INTERP_SEL_EN
    $display("[TB] zero-order hold");
    src[0][0] = 16'sd100; src[0][1] = 16'sd200;
    doReset();
    interp_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(16'h0800, 1'b0, 1'b0);
      checkOutput("zoh_dut", dut_last[0], lit4[i]);
      checkOutput("zoh_model", m_last[0], lit4[i]);
    end
    interp_mode = 1'b0;
`endif

    $display("[TB] random sweeps");
    fillRandom();
    doReset();
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(9))
        0:       rs = 16'h0000;
        1:       rs = 16'hFFFF;
        default: rs = step_t'($urandom_range(16'h4FFF));
      endcase
      valid_pct = int'($urandom_range(30, 100));
`ifdef RESAMPLER_INTERP_SEL_EN
      interp_mode = 1'($urandom_range(1));
`endif
      applyStimulus(rs, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
